// File: rtl/uart_rx_channel.sv
// UART receive channel: synchroniser, oversampled 5-8 bit receiver with parity/stop/break
// checking, and a first-word-fall-through RX FIFO with threshold and character-timeout flags.
`timescale 1ns/1ps
module uart_rx_channel #(
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 3,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                          uart_clk,
  input  logic                          rst_n,
  input  logic                          sample_tick,
  input  logic                          rx_serial,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic [$clog2(FIFO_DEPTH):0]   cfg_rx_thresh,
  input  logic                          fifo_reset,
  input  logic                          err_clear,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic [2:0]                    rd_status,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_thresh_hit,
  output logic                          rx_timeout,
  output logic                          rx_active,
  output logic                          overrun_error
);

  localparam int LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_CHARS * 10 * OVERSAMPLE;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRK_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_sync;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_serial};
  end
  assign rx_sync = sync_reg[SYNC_STAGES-1];

  state_t         state_reg, state_next;
  logic [CW-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     data_reg, data_next;
  logic           par_bit_reg, par_bit_next;
  logic           fe_reg, fe_next;
  logic           stop_low_reg, stop_low_next;
  logic           stop_idx_reg, stop_idx_next;
  logic [1:0]     nbits_reg, nbits_next;
  logic           par_en_reg, par_en_next;
  logic           par_odd_reg, par_odd_next;
  logic           stop2_reg, stop2_next;
  logic           push_valid;
  logic [10:0]    push_word;
  logic           fe_now, low_now, brk_now, pe_now;

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    par_bit_next  = par_bit_reg;
    fe_next       = fe_reg;
    stop_low_next = stop_low_reg;
    stop_idx_next = stop_idx_reg;
    nbits_next    = nbits_reg;
    par_en_next   = par_en_reg;
    par_odd_next  = par_odd_reg;
    stop2_next    = stop2_reg;
    push_valid    = 1'b0;
    push_word     = '0;
    fe_now        = fe_reg | ~rx_sync;
    low_now       = stop_low_reg & ~rx_sync;
    brk_now       = (data_reg == 8'h00) && low_now && !(par_en_reg && par_bit_reg);
    pe_now        = par_en_reg && ((^data_reg ^ par_bit_reg) != par_odd_reg);
    if (sample_tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_next    = ST_START;
            tick_cnt_next = '0;
            nbits_next    = cfg_data_bits;
            par_en_next   = cfg_parity_en;
            par_odd_next  = cfg_parity_odd;
            stop2_next    = cfg_stop2;
          end
        end
        ST_START: begin
          if (tick_cnt_reg == CW'(OVERSAMPLE/2 - 1)) begin
            tick_cnt_next = '0;
            if (rx_sync) begin
              state_next = ST_IDLE;
            end else begin
              state_next    = ST_DATA;
              bit_cnt_next  = '0;
              data_next     = '0;
              par_bit_next  = 1'b0;
              fe_next       = 1'b0;
              stop_low_next = 1'b1;
              stop_idx_next = 1'b0;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt_reg == CW'(OVERSAMPLE - 1)) begin
            tick_cnt_next          = '0;
            data_next[bit_cnt_reg] = rx_sync;
            // last data bit index is 4 + cfg code (5..8 bits)
            if (bit_cnt_reg == 3'd4 + {1'b0, nbits_reg})
              state_next = par_en_reg ? ST_PARITY : ST_STOP;
            else
              bit_cnt_next = bit_cnt_reg + 3'd1;
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
        ST_PARITY: begin
          if (tick_cnt_reg == CW'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            par_bit_next  = rx_sync;
            state_next    = ST_STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt_reg == CW'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            if (stop2_reg && !stop_idx_reg) begin
              stop_idx_next = 1'b1;
              fe_next       = fe_now;
              stop_low_next = low_now;
            end else begin
              push_valid = 1'b1;
              push_word  = {brk_now, fe_now, pe_now, data_reg};
              state_next = brk_now ? ST_BRK_WAIT : ST_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + CW'(1);
          end
        end
        ST_BRK_WAIT: begin
          if (rx_sync) begin
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      par_bit_reg  <= 1'b0;
      fe_reg       <= 1'b0;
      stop_low_reg <= 1'b0;
      stop_idx_reg <= 1'b0;
      nbits_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      par_bit_reg  <= par_bit_next;
      fe_reg       <= fe_next;
      stop_low_reg <= stop_low_next;
      stop_idx_reg <= stop_idx_next;
      nbits_reg    <= nbits_next;
      par_en_reg   <= par_en_next;
      par_odd_reg  <= par_odd_next;
      stop2_reg    <= stop2_next;
    end
  end

  logic [10:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          overrun_reg, timeout_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          do_pop, do_push, overrun_set;
  logic [10:0]   head;

  assign do_pop      = rd_en & ~rx_empty;
  assign do_push     = push_valid & (~rx_full | do_pop) & ~fifo_reset;
  assign overrun_set = push_valid & rx_full & ~do_pop & ~fifo_reset;

  always_ff @(posedge uart_clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (fifo_reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
      end
      // a new overrun outranks a clear arriving in the same cycle
      if (overrun_set)                  overrun_reg <= 1'b1;
      else if (err_clear || fifo_reset) overrun_reg <= 1'b0;
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (fifo_reset || do_push || do_pop || rx_empty) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (sample_tick && state_reg == ST_IDLE && !timeout_reg) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
      if (to_cnt_reg == TW'(TO_LIMIT - 1)) timeout_reg <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr_reg];
  assign rx_empty      = (level_reg == '0);
  assign rx_full       = (level_reg == LW'(FIFO_DEPTH));
  assign rx_level      = level_reg;
  assign rd_data       = rx_empty ? 8'h00 : head[7:0];
  assign rd_status     = rx_empty ? 3'b000 : head[10:8];
  assign rx_thresh_hit = (cfg_rx_thresh != '0) && (level_reg >= cfg_rx_thresh);
  assign rx_timeout    = timeout_reg;
  assign rx_active     = (state_reg != ST_IDLE);
  assign overrun_error = overrun_reg;

endmodule

// File: tb/tb_uart_rx_channel.sv
// Bench for uart_rx_channel: directed serial frames, expected FIFO entries queued at send time
// and compared by a monitor whenever an entry is popped.
`timescale 1ns/1ps
module tb_uart_rx_channel;

  localparam int OS = 16;

  logic       uart_clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       rx_serial;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic [4:0] cfg_rx_thresh;
  logic       fifo_reset;
  logic       err_clear;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [2:0] rd_status;
  logic       rx_empty;
  logic       rx_full;
  logic [4:0] rx_level;
  logic       rx_thresh_hit;
  logic       rx_timeout;
  logic       rx_active;
  logic       overrun_error;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  uart_rx_channel dut (
    .uart_clk      (uart_clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .rx_serial     (rx_serial),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .cfg_rx_thresh (cfg_rx_thresh),
    .fifo_reset    (fifo_reset),
    .err_clear     (err_clear),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_status     (rd_status),
    .rx_empty      (rx_empty),
    .rx_full       (rx_full),
    .rx_level      (rx_level),
    .rx_thresh_hit (rx_thresh_hit),
    .rx_timeout    (rx_timeout),
    .rx_active     (rx_active),
    .overrun_error (overrun_error)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every pop of a non-empty FIFO is one transaction checked against the queue.
  always @(negedge uart_clk) begin
    if (rst_n && rd_en && !rx_empty) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_entry: got data=%02h status=%03b, expected none", rd_data, rd_status);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("pop data=%02h status=%03b (expect %02h/%03b)", rd_data, rd_status,
                 mon_exp[7:0], mon_exp[10:8]);
        check("rd_data", 32'(rd_data), 32'(mon_exp[7:0]));
        check("rd_status", 32'(rd_status), 32'(mon_exp[10:8]));
      end
    end
  end

  // All stimulus code resumes one time unit after a rising edge.
  task automatic send_bit(input logic v);
    rx_serial = v;
    repeat (OS) @(posedge uart_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_val, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_en) send_bit(par_val);
    for (int s = 0; s < nstop; s++) send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1);
  endtask

  task automatic set_cfg(input logic [1:0] nb, input bit pen, input bit podd, input bit s2);
    cfg_data_bits  = nb;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop2      = s2;
  endtask

  task automatic read_n(input int n);
    rd_en = 1'b1;
    repeat (n) @(posedge uart_clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) fifo_reset = 1'b1; else err_clear = 1'b1;
    @(posedge uart_clk);
    #1;
    fifo_reset = 1'b0;
    err_clear  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    sample_tick   = 1'b1;
    rx_serial     = 1'b1;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    cfg_rx_thresh = 5'd0;
    fifo_reset    = 1'b0;
    err_clear     = 1'b0;
    rd_en         = 1'b0;
    repeat (3) @(posedge uart_clk);
    #1;
    check("reset_empty", 32'(rx_empty), 32'd1);
    check("reset_level", 32'(rx_level), 32'd0);
    check("reset_full", 32'(rx_full), 32'd0);
    check("reset_active", 32'(rx_active), 32'd0);
    check("reset_overrun", 32'(overrun_error), 32'd0);
    check("reset_timeout", 32'(rx_timeout), 32'd0);
    check("reset_thresh", 32'(rx_thresh_hit), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_status", 32'(rd_status), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge uart_clk);
    #1;

    // Asynchronous reset in the middle of a frame discards it.
    rx_serial = 1'b0;
    repeat (40) @(posedge uart_clk);
    #1;
    check("midframe_active", 32'(rx_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_active", 32'(rx_active), 32'd0);
    rx_serial = 1'b1;
    repeat (3) @(posedge uart_clk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge uart_clk);
    #1;
    check("async_reset_discard", 32'(rx_level), 32'd0);

    // 8N1 0xA5
    exp_q.push_back({3'b000, 8'hA5});
    send_8n1(8'hA5);
    check("a5_level", 32'(rx_level), 32'd1);
    check("a5_head", 32'(rd_data), 32'hA5);
    check("a5_active", 32'(rx_active), 32'd0);
    read_n(1);
    check("a5_empty", 32'(rx_empty), 32'd1);

    // rd_en on an empty FIFO is ignored
    read_n(1);
    check("empty_rd_level", 32'(rx_level), 32'd0);
    check("empty_rd_data", 32'(rd_data), 32'd0);

    // 7E2: bad then good parity
    set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({3'b001, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b1, 2);
    exp_q.push_back({3'b000, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b0, 2);
    check("7e2_level", 32'(rx_level), 32'd2);
    read_n(2);

    // Break: line low 12 bit times gives exactly one entry
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({3'b110, 8'h00});
    rx_serial = 1'b0;
    repeat (12 * OS) @(posedge uart_clk);
    #1;
    check("brk_level", 32'(rx_level), 32'd1);
    check("brk_wait_active", 32'(rx_active), 32'd1);
    rx_serial = 1'b1;
    repeat (2 * OS) @(posedge uart_clk);
    #1;
    check("brk_level_after", 32'(rx_level), 32'd1);
    check("brk_idle", 32'(rx_active), 32'd0);
    read_n(1);

    // Overrun: 17 characters into 16 entries
    pulse(0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({3'b000, 8'(i + 1)});
      send_8n1(8'(i + 1));
    end
    check("ovr_level", 32'(rx_level), 32'd16);
    check("ovr_full", 32'(rx_full), 32'd1);
    check("ovr_flag", 32'(overrun_error), 32'd1);
    pulse(1);
    check("ovr_cleared", 32'(overrun_error), 32'd0);

    // Full FIFO with rd_en in the push cycle (final stop sample lands 156 edges after start)
    exp_q.push_back({3'b000, 8'h55});
    fork
      send_8n1(8'h55);
      begin
        repeat (155) @(posedge uart_clk);
        #1;
        rd_en = 1'b1;
        @(posedge uart_clk);
        #1;
        rd_en = 1'b0;
      end
    join
    check("fullrw_level", 32'(rx_level), 32'd16);
    check("fullrw_overrun", 32'(overrun_error), 32'd0);
    read_n(16);
    check("drain_empty", 32'(rx_empty), 32'd1);

    // Character timeout: 4*10*16 idle ticks after the push
    check("to_idle", 32'(rx_timeout), 32'd0);
    exp_q.push_back({3'b000, 8'h3C});
    fork
      send_8n1(8'h3C);
      begin
        repeat (795) @(posedge uart_clk);
        #1;
        check("to_early", 32'(rx_timeout), 32'd0);
        @(posedge uart_clk);
        #1;
        check("to_set", 32'(rx_timeout), 32'd1);
      end
    join
    read_n(1);
    check("to_cleared", 32'(rx_timeout), 32'd0);

    // Threshold
    cfg_rx_thresh = 5'd2;
    exp_q.push_back({3'b000, 8'h12});
    send_8n1(8'h12);
    check("thresh_one", 32'(rx_thresh_hit), 32'd0);
    exp_q.push_back({3'b000, 8'h34});
    send_8n1(8'h34);
    check("thresh_two", 32'(rx_thresh_hit), 32'd1);
    cfg_rx_thresh = 5'd0;
    @(posedge uart_clk);
    #1;
    check("thresh_disabled", 32'(rx_thresh_hit), 32'd0);
    read_n(2);
    check("final_empty", 32'(rx_empty), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
